// File: rtl/uart_loader.sv
// Boot-time program loader: receives an 8N1 UART image (16-bit big-endian word count,
// then little-endian 32-bit words) and writes it into instruction memory from address 0.
module uart_loader #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115_200,
    parameter int ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      CAPACITY = 17'(2 ** ADDR_W);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE, ERR} ld_state_t;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        r_state_q, r_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_vld_q, byte_vld_d;
    logic             frame_err_q, frame_err_d;

    ld_state_t         ld_q, ld_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_q, word_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic [15:0]       hdr_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            r_state_q    <= R_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_vld_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            ld_q         <= IDLE;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            r_state_q    <= r_state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_vld_q   <= byte_vld_d;
            frame_err_q  <= frame_err_d;
            ld_q         <= ld_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    // Byte receiver: mid-bit sampling, a start bit that is high again at mid-bit is a glitch.
    always_comb begin
        r_state_d   = r_state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) r_state_d = R_START;
            end
            R_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    r_state_d = rx_sync_q ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) r_state_d = R_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d       = '0;
                    byte_vld_d  = rx_sync_q;
                    frame_err_d = !rx_sync_q;
                    r_state_d   = R_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign hdr_count = {count_q[15:8], shift_q};

    always_comb begin
        ld_d         = ld_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        case (ld_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    ld_d       = HDR0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                end
            end
            HDR0: begin
                if (frame_err_q) begin
                    ld_d = ERR;
                end else if (byte_vld_q) begin
                    count_d[15:8] = shift_q;
                    ld_d          = HDR1;
                end
            end
            HDR1: begin
                if (frame_err_q) begin
                    ld_d = ERR;
                end else if (byte_vld_q) begin
                    count_d = hdr_count;
                    if (hdr_count == 16'd0)                  ld_d = DONE;
                    else if ({1'b0, hdr_count} > CAPACITY)   ld_d = ERR;
                    else                                     ld_d = DATA;
                end
            end
            DATA: begin
                // Completion is checked the cycle after the strobe so done follows the last write.
                if (frame_err_q) begin
                    ld_d = ERR;
                end else if (imem_we_q && (16'(word_idx_q) == count_q)) begin
                    ld_d = DONE;
                end else if (byte_vld_q) begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = shift_q;
                        2'd1: word_d[15:8]  = shift_q;
                        2'd2: word_d[23:16] = shift_q;
                        default: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = word_idx_q[ADDR_W-1:0];
                            imem_wdata_d = {shift_q, word_q};
                            word_idx_d   = word_idx_q + 1'b1;
                        end
                    endcase
                end
            end
            default: ld_d = IDLE;
        endcase
    end

    assign busy       = (ld_q == HDR0) || (ld_q == HDR1) || (ld_q == DATA);
    assign cpu_hold   = busy;
    assign done       = (ld_q == DONE);
    assign err        = (ld_q == ERR);
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
endmodule
